fc_rx_credit_buffer: RTL

FC_RX_CREDIT_BUFFER -- requirements
Module: fc_rx_credit_buffer

---
 rtl/fc_pkg.sv | 18 +
 rtl/fc_sync_fifo.sv | 79 +++++++
 rtl/fc_rx_credit_buffer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fc_pkg.sv
// Shared constants and types for the receive-side credit buffer.
package fc_pkg;

  // Credit type tags carried in the top bits of credit_limit.
  localparam logic [2:0] BUF_PH   = 3'b000;
  localparam logic [2:0] BUF_PD   = 3'b001;
  localparam logic [2:0] BUF_NPH  = 3'b010;
  localparam logic [2:0] BUF_NPD  = 3'b011;
  localparam logic [2:0] BUF_CPLH = 3'b100;
  localparam logic [2:0] BUF_CPLD = 3'b101;

  // Credit update handshake states.
  typedef enum logic [0:0] {
    StIdle,
    StPending
  } upd_state_e;

endpackage

// File: rtl/fc_sync_fifo.sv
// Storage FIFO with registered read data; a write into a full FIFO is only
// taken when a read is accepted in the same cycle.
module fc_sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          data_valid,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          rd_accept
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CountW = PtrW + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q;
  logic [PtrW-1:0]       rd_ptr_q;
  logic [CountW-1:0]     count_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  data_valid_q;
  logic                  wr_accept;

  // Accept decisions and status flags derived from current occupancy.
  always_comb begin
    full      = (count_q == CountW'(FIFO_DEPTH));
    empty     = (count_q == '0);
    rd_accept = rd_en && !empty;
    wr_accept = wr_en && (!full || rd_accept);
    count     = count_q;
    data_out  = data_out_q;
    data_valid = data_valid_q;
  end

  // Storage array; not reset since entries are only read after being written.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_accept) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (rd_accept) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (wr_accept && !rd_accept) begin
        count_q <= count_q + CountW'(1);
      end else if (rd_accept && !wr_accept) begin
        count_q <= count_q - CountW'(1);
      end
    end
  end

  // Registered read port: data appears the cycle after an accepted read.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_valid_q <= rd_accept;
      if (rd_accept) begin
        data_out_q <= mem[rd_ptr_q];
      end
    end
  end

endmodule

// File: rtl/fc_rx_credit_buffer.sv
// Receive credit buffer: FIFO storage plus credit accounting and a credit
// advertisement handshake with a periodic forced re-advertisement.
module fc_rx_credit_buffer
  import fc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned CREDIT_WIDTH   = 8,
  parameter logic [2:0]  BUFFER_TYPE    = BUF_PH,
  parameter int unsigned UPDATE_TIMEOUT = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          data_valid,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic [CREDIT_WIDTH+2:0]       credit_limit,
  output logic                          update_req,
  input  logic                          update_ack,
  output logic                          overflow_err,
  input  logic                          clr_err
);

  localparam int unsigned TimerW = $clog2(UPDATE_TIMEOUT);
  localparam logic [CREDIT_WIDTH-1:0] InitCredits = CREDIT_WIDTH'(FIFO_DEPTH);

  logic                    rd_accept;
  logic [CREDIT_WIDTH-1:0] credits_q;
  logic [CREDIT_WIDTH-1:0] advertised_q;
  logic [CREDIT_WIDTH+2:0] credit_limit_q;
  logic [TimerW-1:0]       timer_q;
  logic                    overflow_q;
  logic                    load_limit;
  upd_state_e              state_q, state_d;

  fc_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .data_in    (data_in),
    .rd_en      (rd_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .rd_accept  (rd_accept)
  );

  // Every drained entry frees one credit; the counter simply wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits_q <= InitCredits;
    end else if (rd_accept) begin
      credits_q <= credits_q + CREDIT_WIDTH'(1);
    end
  end

  // Update FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Update FSM next state: advertise on credit change or idle timeout.
  always_comb begin
    state_d    = state_q;
    load_limit = 1'b0;
    case (state_q)
      StIdle: begin
        if ((credits_q != advertised_q) || (timer_q == TimerW'(UPDATE_TIMEOUT - 1))) begin
          state_d    = StPending;
          load_limit = 1'b1;
        end
      end
      StPending: begin
        if (update_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Update FSM outputs.
  always_comb begin
    update_req   = (state_q == StPending);
    credit_limit = credit_limit_q;
    overflow_err = overflow_q;
  end

  // Idle timer runs only while staying in IDLE; any transition clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
    end else if ((state_q == StIdle) && (state_d == StIdle)) begin
      timer_q <= timer_q + TimerW'(1);
    end else begin
      timer_q <= '0;
    end
  end

  // Advertised value snapshot: credit_limit is frozen while PENDING, then
  // committed to advertised on ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_limit_q <= {BUFFER_TYPE, InitCredits};
      advertised_q   <= InitCredits;
    end else begin
      if (load_limit) begin
        credit_limit_q <= {BUFFER_TYPE, credits_q};
      end
      if ((state_q == StPending) && update_ack) begin
        advertised_q <= credit_limit_q[CREDIT_WIDTH-1:0];
      end
    end
  end

  // Sticky overflow flag; a new overflow beats a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (wr_en && full && !rd_accept) begin
      overflow_q <= 1'b1;
    end else if (clr_err) begin
      overflow_q <= 1'b0;
    end
  end

endmodule
